// File: rtl/zed_led_driver_if.sv
// LED driver bundle: shared timing config, per-LED mode/level requests and registered drive.
// Purely combinational wiring; no latency and no backpressure.
interface zed_led_driver_if #(
  parameter int LED_COUNT        = 8,
  parameter int PRESCALE_WIDTH   = 24,
  parameter int PWM_WIDTH        = 8,
  parameter int TICK_COUNT_WIDTH = 8
);
  logic [PRESCALE_WIDTH-1:0]   prescale;
  logic [TICK_COUNT_WIDTH-1:0] blink_ticks;
  logic [TICK_COUNT_WIDTH-1:0] stretch_ticks;
  logic [PWM_WIDTH-1:0]        duty;
  logic [2*LED_COUNT-1:0]      mode;
  logic [LED_COUNT-1:0]        level;
  logic [LED_COUNT-1:0]        led;
  logic                        tick;

  modport master (
    output prescale, blink_ticks, stretch_ticks, duty, mode, level,
    input  led, tick
  );

  modport slave (
    input  prescale, blink_ticks, stretch_ticks, duty, mode, level,
    output led, tick
  );
endinterface

// File: rtl/zed_led_driver.sv
// Per-LED drive (direct / stretch / blink / PWM) from one shared prescaler tick.
// One clock from level to led; always accepts input, no backpressure.
module zed_led_driver #(
  parameter int LED_COUNT        = 8,
  parameter int PRESCALE_WIDTH   = 24,
  parameter int PWM_WIDTH        = 8,
  parameter int TICK_COUNT_WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  zed_led_driver_if.slave  bus
);

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_STRETCH = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_PWM     = 2'b11;

  logic [PRESCALE_WIDTH-1:0]   presc_cnt;
  logic                        tick;
  logic [PWM_WIDTH-1:0]        pwm_cnt;
  logic                        pwm_on;
  logic [TICK_COUNT_WIDTH-1:0] blink_cnt;
  logic                        blink_phase;
  logic [LED_COUNT-1:0]        level_q;
  logic [LED_COUNT-1:0]        rise;
  logic [TICK_COUNT_WIDTH-1:0] stretch_cnt [LED_COUNT];
  logic [LED_COUNT-1:0]        led_next;
  logic [LED_COUNT-1:0]        led_q;

  // >= rather than == so a prescale lowered below the running count still wraps at once.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else if (presc_cnt >= bus.prescale) begin
      presc_cnt <= '0;
      tick      <= 1'b1;
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
      tick      <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
    end
  end

  assign pwm_on = (pwm_cnt < bus.duty);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt >= bus.blink_ticks) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + TICK_COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q <= '0;
    end else begin
      level_q <= bus.level;
    end
  end

  assign rise = bus.level & ~level_q;

  // A fresh rising edge reloads even when it lands on a tick, so retriggers never lose a tick.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int n = 0; n < LED_COUNT; n++) begin
        stretch_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < LED_COUNT; n++) begin
        if (bus.mode[2*n +: 2] != MODE_STRETCH) begin
          stretch_cnt[n] <= '0;
        end else if (rise[n]) begin
          stretch_cnt[n] <= bus.stretch_ticks;
        end else if (tick && (stretch_cnt[n] != '0)) begin
          stretch_cnt[n] <= stretch_cnt[n] - TICK_COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    led_next = '0;
    for (int n = 0; n < LED_COUNT; n++) begin
      case (bus.mode[2*n +: 2])
        MODE_DIRECT:  led_next[n] = bus.level[n];
        MODE_STRETCH: led_next[n] = bus.level[n] | (stretch_cnt[n] != '0);
        MODE_BLINK:   led_next[n] = bus.level[n] & blink_phase;
        MODE_PWM:     led_next[n] = bus.level[n] & pwm_on;
        default:      led_next[n] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_next;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_zed_led_driver.sv
// Bench for zed_led_driver: directed scenarios plus randomized traffic against a reference model.
module tb_zed_led_driver;

  localparam int LEDS = 8;
  localparam int PW   = 24;
  localparam int DW   = 8;
  localparam int TW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  zed_led_driver_if #(.LED_COUNT(LEDS), .PRESCALE_WIDTH(PW), .PWM_WIDTH(DW), .TICK_COUNT_WIDTH(TW)) bus ();

  zed_led_driver #(.LED_COUNT(LEDS), .PRESCALE_WIDTH(PW), .PWM_WIDTH(DW), .TICK_COUNT_WIDTH(TW)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec rules in plain arithmetic. Blink phase and PWM are derived from
  // tick/clock totals since reset; stretch tracks ticks elapsed since the last rising edge.
  int         m_elapsed;
  int         m_edges;
  int         m_blinks;
  bit         m_tick;
  logic [7:0] m_led;
  logic [7:0] m_prev;
  bit         m_active [LEDS];
  int         m_since  [LEDS];

  int hi_cnt [LEDS];
  int tick_cnt;

  task automatic clear_counts();
    for (int n = 0; n < LEDS; n++) hi_cnt[n] = 0;
    tick_cnt = 0;
  endtask

  task automatic model_reset();
    m_elapsed = 0;
    m_edges   = 0;
    m_blinks  = 0;
    m_tick    = 1'b0;
    m_led     = '0;
    m_prev    = '0;
    for (int n = 0; n < LEDS; n++) begin
      m_active[n] = 1'b0;
      m_since[n]  = 0;
    end
  endtask

  task automatic model_step();
    bit         pwm_on, phase, lit, new_tick;
    int         bt, s;
    logic [1:0] m;
    logic [7:0] nxt;
    pwm_on = (m_edges % 256) < int'(bus.duty);
    m_edges++;
    bt    = int'(bus.blink_ticks);
    phase = ((m_blinks / (bt + 1)) % 2) == 1;
    s     = int'(bus.stretch_ticks);
    nxt   = '0;
    for (int n = 0; n < LEDS; n++) begin
      m   = bus.mode[2*n +: 2];
      lit = m_active[n] && (m_since[n] < s);
      case (m)
        2'd0:    nxt[n] = bus.level[n];
        2'd1:    nxt[n] = bus.level[n] | lit;
        2'd2:    nxt[n] = bus.level[n] & phase;
        default: nxt[n] = bus.level[n] & pwm_on;
      endcase
      if (m != 2'd1) begin
        m_active[n] = 1'b0;
      end else if (bus.level[n] && !m_prev[n]) begin
        m_active[n] = 1'b1;
        m_since[n]  = 0;
      end else if (m_tick && m_active[n] && (m_since[n] < s)) begin
        m_since[n]++;
      end
    end
    m_prev = bus.level;
    m_led  = nxt;
    if (m_tick) m_blinks++;
    new_tick  = m_elapsed >= int'(bus.prescale);
    m_elapsed = new_tick ? 0 : m_elapsed + 1;
    m_tick    = new_tick;
  endtask

  task automatic randomize_inputs();
    if ($urandom_range(3) == 0) bus.level = bus.level ^ (8'd1 << $urandom_range(7));
    if ($urandom_range(15) == 0) bus.mode = 16'($urandom);
    if ($urandom_range(31) == 0) bus.duty = 8'($urandom);
  endtask

  // Inputs change #1 after the active edge; outputs are checked at the same point.
  task automatic run_cycles(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check_val("led", 32'(bus.led), 32'(m_led));
      check_val("tick", 32'(bus.tick), 32'(m_tick));
      for (int k = 0; k < LEDS; k++) if (bus.led[k]) hi_cnt[k]++;
      if (bus.tick) tick_cnt++;
      if (rnd) randomize_inputs();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    clear_counts();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] lvl;
    bit         found;

    bus.prescale      = 24'd3;
    bus.blink_ticks   = 8'd1;
    bus.stretch_ticks = 8'd5;
    bus.duty          = 8'd64;
    bus.mode          = '0;
    bus.level         = '0;
    do_reset();
    check_val("rst_led", 32'(bus.led), 32'h0);
    check_val("rst_tick", 32'(bus.tick), 32'h0);

    // Direct mode, then a toggling level tracked with one clock of lag.
    bus.level = 8'hA5;
    run_cycles(1, 1'b0);
    check_val("direct_a5", 32'(bus.led), 32'hA5);
    lvl = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      lvl       = ~lvl;
      bus.level = lvl;
      run_cycles(1, 1'b0);
      check_val("direct_toggle", 32'(bus.led), 32'(lvl));
    end

    // Blink: tick every 4 clocks, 8 on / 8 off starting off.
    bus.level = '0;
    bus.mode  = 16'h0002;
    do_reset();
    bus.level = 8'h01;
    run_cycles(64, 1'b0);
    check_val("blink_ticks", 32'(tick_cnt), 32'd16);
    check_val("blink_on", 32'(hi_cnt[0]), 32'd31);

    // Stretch: single pulse, retrigger, then a rise landing on a tick.
    bus.level = '0;
    bus.mode  = 16'h0004;
    do_reset();
    run_cycles(2, 1'b0);
    clear_counts();
    bus.level = 8'h02;
    run_cycles(1, 1'b0);
    bus.level = 8'h00;
    run_cycles(40, 1'b0);
    check_val("stretch_len", 32'(hi_cnt[1]), 32'd19);
    bus.level = 8'h02;
    run_cycles(1, 1'b0);
    bus.level = 8'h00;
    run_cycles(10, 1'b0);
    bus.level = 8'h02;
    run_cycles(1, 1'b0);
    bus.level = 8'h00;
    run_cycles(30, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      run_cycles(1, 1'b0);
      found = m_tick;
    end
    check_val("tick_align", 32'(found), 32'd1);
    bus.level = 8'h02;
    run_cycles(1, 1'b0);
    bus.level = 8'h00;
    run_cycles(30, 1'b0);

    // PWM duty window counts.
    bus.mode  = 16'h0030;
    do_reset();
    bus.level = 8'h04;
    bus.duty  = 8'd64;
    run_cycles(256, 1'b0);
    check_val("pwm_64", 32'(hi_cnt[2]), 32'd64);
    bus.duty = 8'd0;
    clear_counts();
    run_cycles(256, 1'b0);
    check_val("pwm_0", 32'(hi_cnt[2]), 32'd0);
    bus.duty = 8'd255;
    clear_counts();
    run_cycles(256, 1'b0);
    check_val("pwm_255", 32'(hi_cnt[2]), 32'd255);

    // Prescale lowered below the running count.
    bus.level    = '0;
    bus.mode     = '0;
    bus.prescale = 24'd20;
    do_reset();
    run_cycles(10, 1'b0);
    bus.prescale = 24'd5;
    run_cycles(1, 1'b0);
    check_val("presc_lower_tick", 32'(bus.tick), 32'd1);
    clear_counts();
    run_cycles(12, 1'b0);
    check_val("presc_lower_rate", 32'(tick_cnt), 32'd2);

    // Randomized segments, each with its own timing configuration.
    for (int seg = 0; seg < 6; seg++) begin
      bus.prescale      = 24'($urandom_range(6));
      bus.blink_ticks   = 8'($urandom_range(3));
      bus.stretch_ticks = 8'($urandom_range(6));
      bus.duty          = 8'($urandom);
      bus.mode          = 16'($urandom);
      bus.level         = 8'($urandom);
      do_reset();
      run_cycles(400, 1'b1);
    end

    // Asynchronous reset in the middle of a cycle with all LEDs lit.
    bus.mode  = '0;
    bus.level = 8'hFF;
    run_cycles(3, 1'b0);
    check_val("pre_rst_led", 32'(bus.led), 32'hFF);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_rst_led", 32'(bus.led), 32'h0);
    check_val("async_rst_tick", 32'(bus.tick), 32'h0);
    bus.prescale = 24'd3;
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(3, 1'b0);
    check_val("no_early_tick", 32'(bus.tick), 32'd0);
    run_cycles(1, 1'b0);
    check_val("first_tick", 32'(bus.tick), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
